// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller: OCW2 command codes (R, SL, EOI)
// and the acknowledge-sequence state encoding.
package pic_pkg;

    localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] OCW2_NSEOI        = 3'b001;
    localparam logic [2:0] OCW2_NOP          = 3'b010;
    localparam logic [2:0] OCW2_SEOI         = 3'b011;
    localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] OCW2_ROT_NSEOI    = 3'b101;
    localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
    localparam logic [2:0] OCW2_ROT_SEOI     = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } ack_state_e;

endpackage

// File: rtl/pic_priority_resolver.sv
// Rotating find-first: returns the set bit of vec with the highest priority,
// where priority starts at lowest_prio+1 and descends modulo NUM_IRQ.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    localparam int LVL_W  = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [LVL_W-1:0]   lowest_prio,
    output logic               found,
    output logic [LVL_W-1:0]   level
);

    logic [LVL_W:0] idx;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found = 1'b0;
        level = '0;
        idx   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            idx = {1'b0, lowest_prio} + (LVL_W + 1)'(i + 1);
            if (idx >= (LVL_W + 1)'(NUM_IRQ)) begin
                idx = idx - (LVL_W + 1)'(NUM_IRQ);
            end
            if (vec[idx[LVL_W-1:0]]) begin
                found = 1'b1;
                level = idx[LVL_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pic_in_service_ctrl.sv
// In-service controller: ISR, rotating priority pointer, two-pulse INTA sequence
// and OCW2 end-of-interrupt / rotation commands.
module pic_in_service_ctrl
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    localparam int LVL_W  = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_pending,
    input  logic               aeoi_en,
    input  logic               special_mask_en,
    input  logic               inta_first,
    input  logic               inta_second,
    input  logic               ocw2_valid,
    input  logic [2:0]         ocw2_cmd,
    input  logic [LVL_W-1:0]   ocw2_level,
    output logic [NUM_IRQ-1:0] isr,
    output logic               int_req,
    output logic               vector_valid,
    output logic [LVL_W-1:0]   vector_level,
    output logic [LVL_W-1:0]   lowest_prio
);

    localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_IRQ - 1);

    ack_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d, isr_set, isr_clr, req_vec;
    logic [LVL_W-1:0]   lp_q, lp_d, ack_lvl_q, ack_lvl_d, vec_lvl_q, vec_lvl_d;
    logic               rot_aeoi_q, rot_aeoi_d, spur_q, spur_d;
    logic               int_req_q, int_req_d, vec_vld_q, vec_vld_d;
    logic               req_found, isr_found, eligible, ocw2_lvl_ok;
    logic [LVL_W-1:0]   req_lvl, isr_lvl;

    // Position in the current priority order; 0 is the highest priority.
    function automatic logic [LVL_W:0] prio_rank(input logic [LVL_W-1:0] lvl,
                                                 input logic [LVL_W-1:0] lp);
        if (lvl > lp) begin
            return {1'b0, lvl} - {1'b0, lp} - (LVL_W + 1)'(1);
        end
        return {1'b0, lvl} + (LVL_W + 1)'(NUM_IRQ) - {1'b0, lp} - (LVL_W + 1)'(1);
    endfunction

    // Special mask mode lets any level not already in service through.
    assign req_vec = special_mask_en ? (irq_pending & ~isr_q) : irq_pending;

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_req_resolver (
        .vec        (req_vec),
        .lowest_prio(lp_q),
        .found      (req_found),
        .level      (req_lvl)
    );

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_resolver (
        .vec        (isr_q),
        .lowest_prio(lp_q),
        .found      (isr_found),
        .level      (isr_lvl)
    );

    assign eligible = req_found &&
                      (special_mask_en || !isr_found ||
                       (prio_rank(req_lvl, lp_q) < prio_rank(isr_lvl, lp_q)));

    assign ocw2_lvl_ok = ({1'b0, ocw2_level} < (LVL_W + 1)'(NUM_IRQ));

    always_comb begin
        state_d    = state_q;
        isr_set    = '0;
        isr_clr    = '0;
        lp_d       = lp_q;
        rot_aeoi_d = rot_aeoi_q;
        ack_lvl_d  = ack_lvl_q;
        spur_d     = spur_q;
        vec_vld_d  = 1'b0;
        vec_lvl_d  = vec_lvl_q;
        int_req_d  = (state_q == ST_IDLE) && !inta_first && eligible;

        case (state_q)
            ST_IDLE: begin
                if (inta_first) begin
                    state_d = ST_ACK;
                    spur_d  = !eligible;
                    if (eligible) begin
                        ack_lvl_d        = req_lvl;
                        isr_set[req_lvl] = 1'b1;
                    end else begin
                        ack_lvl_d = TOP_LVL;
                    end
                end
            end
            ST_ACK: begin
                if (inta_second) begin
                    state_d   = ST_IDLE;
                    vec_vld_d = 1'b1;
                    vec_lvl_d = ack_lvl_q;
                    if (aeoi_en) begin
                        if (!spur_q) begin
                            isr_clr[ack_lvl_q] = 1'b1;
                        end
                        if (rot_aeoi_q) begin
                            lp_d = ack_lvl_q;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Evaluated after the AEOI path so an OCW2 priority write takes precedence.
        if (ocw2_valid && ocw2_lvl_ok) begin
            case (ocw2_cmd)
                OCW2_NSEOI: begin
                    if (isr_found) isr_clr[isr_lvl] = 1'b1;
                end
                OCW2_SEOI: isr_clr[ocw2_level] = 1'b1;
                OCW2_ROT_NSEOI: begin
                    if (isr_found) begin
                        isr_clr[isr_lvl] = 1'b1;
                        lp_d             = isr_lvl;
                    end
                end
                OCW2_ROT_SEOI: begin
                    isr_clr[ocw2_level] = 1'b1;
                    lp_d                = ocw2_level;
                end
                OCW2_SET_PRIO:     lp_d       = ocw2_level;
                OCW2_ROT_AEOI_SET: rot_aeoi_d = 1'b1;
                OCW2_ROT_AEOI_CLR: rot_aeoi_d = 1'b0;
                default: ;
            endcase
        end

        isr_d = (isr_q & ~isr_clr) | isr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            isr_q      <= '0;
            lp_q       <= TOP_LVL;
            rot_aeoi_q <= 1'b0;
            ack_lvl_q  <= '0;
            spur_q     <= 1'b0;
            int_req_q  <= 1'b0;
            vec_vld_q  <= 1'b0;
            vec_lvl_q  <= '0;
        end else begin
            state_q    <= state_d;
            isr_q      <= isr_d;
            lp_q       <= lp_d;
            rot_aeoi_q <= rot_aeoi_d;
            ack_lvl_q  <= ack_lvl_d;
            spur_q     <= spur_d;
            int_req_q  <= int_req_d;
            vec_vld_q  <= vec_vld_d;
            vec_lvl_q  <= vec_lvl_d;
        end
    end

    assign isr          = isr_q;
    assign int_req      = int_req_q;
    assign vector_valid = vec_vld_q;
    assign vector_level = vec_lvl_q;
    assign lowest_prio  = lp_q;

endmodule

// File: tb/tb_pic_in_service_ctrl.sv
// Bench for pic_in_service_ctrl (NUM_IRQ = 8): directed vector table, a reset-in-ACK
// sequence, then randomized traffic against a priority-scan reference model.
module tb_pic_in_service_ctrl;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_pending = '0;
    logic       aeoi_en = 1'b0;
    logic       special_mask_en = 1'b0;
    logic       inta_first = 1'b0;
    logic       inta_second = 1'b0;
    logic       ocw2_valid = 1'b0;
    logic [2:0] ocw2_cmd = '0;
    logic [2:0] ocw2_level = '0;
    logic [7:0] isr;
    logic       int_req;
    logic       vector_valid;
    logic [2:0] vector_level;
    logic [2:0] lowest_prio;

    int n_checks = 0;
    int n_errors = 0;

    pic_in_service_ctrl #(.NUM_IRQ(N)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq_pending    (irq_pending),
        .aeoi_en        (aeoi_en),
        .special_mask_en(special_mask_en),
        .inta_first     (inta_first),
        .inta_second    (inta_second),
        .ocw2_valid     (ocw2_valid),
        .ocw2_cmd       (ocw2_cmd),
        .ocw2_level     (ocw2_level),
        .isr            (isr),
        .int_req        (int_req),
        .vector_valid   (vector_valid),
        .vector_level   (vector_level),
        .lowest_prio    (lowest_prio)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e_isr, input logic e_req,
                             input logic e_vv, input logic [2:0] e_vl, input logic [2:0] e_lp);
        check({tag, ".isr"}, 32'(isr), 32'(e_isr));
        check({tag, ".int_req"}, 32'(int_req), 32'(e_req));
        check({tag, ".vector_valid"}, 32'(vector_valid), 32'(e_vv));
        check({tag, ".vector_level"}, 32'(vector_level), 32'(e_vl));
        check({tag, ".lowest_prio"}, 32'(lowest_prio), 32'(e_lp));
    endtask

    task automatic drive(input logic [7:0] pend, input logic aeoi, input logic smm,
                         input logic i1, input logic i2, input logic ov,
                         input logic [2:0] cmd, input logic [2:0] lvl);
        irq_pending     = pend;
        aeoi_en         = aeoi;
        special_mask_en = smm;
        inta_first      = i1;
        inta_second     = i2;
        ocw2_valid      = ov;
        ocw2_cmd        = cmd;
        ocw2_level      = lvl;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0] pend;
        logic       aeoi, smm, i1, i2, ov;
        logic [2:0] cmd, lvl;
        logic [7:0] e_isr;
        logic       e_req, e_vv;
        logic [2:0] e_vl, e_lp;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(logic [7:0] pend, logic aeoi, logic smm, logic i1, logic i2,
                                logic ov, logic [2:0] cmd, logic [2:0] lvl, logic [7:0] e_isr,
                                logic e_req, logic e_vv, logic [2:0] e_vl, logic [2:0] e_lp);
        row_t r;
        r.pend = pend; r.aeoi = aeoi; r.smm = smm; r.i1 = i1; r.i2 = i2; r.ov = ov;
        r.cmd = cmd; r.lvl = lvl; r.e_isr = e_isr; r.e_req = e_req; r.e_vv = e_vv;
        r.e_vl = e_vl; r.e_lp = e_lp;
        return r;
    endfunction

    // ---------------- reference model ----------------
    bit [7:0] m_isr;
    int       m_lp, m_L, m_vl;
    bit       m_rot, m_ack, m_spur, m_req, m_vv;

    function automatic int prio_lvl(int lp, int k);
        return (lp + 1 + k) % N;
    endfunction

    function automatic int first_set(bit [7:0] v, int lp);
        for (int k = 0; k < N; k++) if (v[prio_lvl(lp, k)]) return prio_lvl(lp, k);
        return -1;
    endfunction

    // Walk the priority order: an in-service level blocks everything below it.
    function automatic int pick(bit [7:0] pend, bit smm);
        if (smm) return first_set(pend & ~m_isr, m_lp);
        for (int k = 0; k < N; k++) begin
            if (m_isr[prio_lvl(m_lp, k)]) return -1;
            if (pend[prio_lvl(m_lp, k)]) return prio_lvl(m_lp, k);
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_isr = '0; m_lp = N - 1; m_L = 0; m_vl = 0;
        m_rot = 0; m_ack = 0; m_spur = 0; m_req = 0; m_vv = 0;
    endtask

    task automatic model_step(input bit [7:0] pend, input bit aeoi, input bit smm, input bit i1,
                              input bit i2, input bit ov, input bit [2:0] cmd, input int lvl);
        int       el, h, nlp, nL, nvl;
        bit [7:0] set_m, clr_m;
        bit       nack, nspur, nvv, nrot;
        el = pick(pend, smm);
        h  = first_set(m_isr, m_lp);
        set_m = '0; clr_m = '0;
        nlp = m_lp; nL = m_L; nvl = m_vl; nack = m_ack; nspur = m_spur; nvv = 0; nrot = m_rot;
        if (!m_ack && i1) begin
            nack = 1;
            nspur = (el < 0);
            if (el >= 0) begin nL = el; set_m[el] = 1; end
            else nL = N - 1;
        end else if (m_ack && i2) begin
            nack = 0; nvv = 1; nvl = m_L;
            if (aeoi) begin
                if (!m_spur) clr_m[m_L] = 1;
                if (m_rot) nlp = m_L;
            end
        end
        if (ov) begin
            case (cmd)
                3'b001: if (h >= 0) clr_m[h] = 1;
                3'b011: clr_m[lvl] = 1;
                3'b101: if (h >= 0) begin clr_m[h] = 1; nlp = h; end
                3'b111: begin clr_m[lvl] = 1; nlp = lvl; end
                3'b110: nlp = lvl;
                3'b100: nrot = 1;
                3'b000: nrot = 0;
                default: ;
            endcase
        end
        m_req  = !m_ack && !i1 && (el >= 0);
        m_isr  = (m_isr & ~clr_m) | set_m;
        m_lp = nlp; m_L = nL; m_vl = nvl; m_ack = nack; m_spur = nspur; m_vv = nvv; m_rot = nrot;
    endtask

    initial begin
        bit [7:0] r_pend;
        bit       r_aeoi, r_smm, r_i1, r_i2, r_ov;
        bit [2:0] r_cmd, r_lvl;

        // pend  aeoi smm i1 i2 ov cmd lvl | isr  req vv vl lp
        tbl.push_back(mk(8'h24, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 1, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h24, 0, 0, 1, 0, 0, 3'd0, 3'd0, 8'h04, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h24, 0, 0, 0, 1, 0, 3'd0, 3'd0, 8'h04, 0, 1, 3'd2, 3'd7));
        tbl.push_back(mk(8'h24, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h04, 0, 0, 3'd2, 3'd7));
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h04, 1, 0, 3'd2, 3'd7));
        tbl.push_back(mk(8'h01, 0, 0, 1, 0, 0, 3'd0, 3'd0, 8'h05, 0, 0, 3'd2, 3'd7));
        tbl.push_back(mk(8'h01, 0, 0, 0, 1, 0, 3'd0, 3'd0, 8'h05, 0, 1, 3'd0, 3'd7));
        tbl.push_back(mk(8'h08, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h05, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h08, 0, 0, 0, 0, 1, 3'd1, 3'd0, 8'h04, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h00, 0, 0, 0, 0, 1, 3'd1, 3'd0, 8'h00, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h00, 1, 0, 0, 0, 1, 3'd4, 3'd0, 8'h00, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h10, 1, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 1, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h10, 1, 0, 1, 0, 0, 3'd0, 3'd0, 8'h10, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h10, 1, 0, 0, 1, 0, 3'd0, 3'd0, 8'h00, 0, 1, 3'd4, 3'd4));
        tbl.push_back(mk(8'h21, 1, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 1, 0, 3'd4, 3'd4));
        tbl.push_back(mk(8'h21, 1, 0, 1, 0, 0, 3'd0, 3'd0, 8'h20, 0, 0, 3'd4, 3'd4));
        tbl.push_back(mk(8'h21, 1, 0, 0, 1, 0, 3'd0, 3'd0, 8'h00, 0, 1, 3'd5, 3'd5));
        tbl.push_back(mk(8'h00, 0, 0, 0, 0, 1, 3'd0, 3'd0, 8'h00, 0, 0, 3'd5, 3'd5));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0, 0, 3'd0, 3'd0, 8'h00, 0, 0, 3'd5, 3'd5));
        tbl.push_back(mk(8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0, 8'h00, 0, 1, 3'd7, 3'd5));
        tbl.push_back(mk(8'h00, 0, 0, 0, 0, 1, 3'd6, 3'd2, 8'h00, 0, 0, 3'd7, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 1, 0, 3'd7, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 1, 0, 0, 3'd0, 3'd0, 8'h08, 0, 0, 3'd7, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 0, 1, 0, 3'd0, 3'd0, 8'h08, 0, 1, 3'd3, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h08, 0, 0, 3'd3, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 0, 0, 1, 3'd3, 3'd3, 8'h00, 0, 0, 3'd3, 3'd2));
        tbl.push_back(mk(8'h09, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00, 1, 0, 3'd3, 3'd2));
        tbl.push_back(mk(8'h01, 0, 0, 1, 0, 0, 3'd0, 3'd0, 8'h01, 0, 0, 3'd3, 3'd2));
        tbl.push_back(mk(8'h01, 0, 0, 0, 1, 0, 3'd0, 3'd0, 8'h01, 0, 1, 3'd0, 3'd2));
        tbl.push_back(mk(8'h01, 0, 0, 0, 0, 1, 3'd6, 3'd7, 8'h01, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h80, 0, 0, 0, 0, 0, 3'd0, 3'd0, 8'h01, 0, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h80, 0, 1, 0, 0, 0, 3'd0, 3'd0, 8'h01, 1, 0, 3'd0, 3'd7));
        tbl.push_back(mk(8'h80, 0, 1, 1, 0, 0, 3'd0, 3'd0, 8'h81, 0, 0, 3'd0, 3'd7));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 8'h00, 0, 0, 3'd0, 3'd7);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].pend, tbl[i].aeoi, tbl[i].smm, tbl[i].i1, tbl[i].i2, tbl[i].ov,
                  tbl[i].cmd, tbl[i].lvl);
            @(posedge clk);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].e_isr, tbl[i].e_req, tbl[i].e_vv,
                      tbl[i].e_vl, tbl[i].e_lp);
        end

        // Reset while waiting for the second INTA: sequence aborts, no vector.
        drive(8'h80, 0, 1, 0, 0, 0, 3'd0, 3'd0);
        rst_n = 1'b0;
        #1;
        check_all("rst_in_ack", 8'h00, 0, 0, 3'd0, 3'd7);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(8'h00, 0, 0, 0, 1, 0, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        check_all("after_rst_inta2", 8'h00, 0, 0, 3'd0, 3'd7);

        // Randomized traffic against the model.
        rst_n = 1'b0;
        drive(8'h00, 0, 0, 0, 0, 0, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        r_smm = 0;
        for (int c = 0; c < 3000; c++) begin
            r_pend = 8'($urandom) & 8'($urandom);
            r_aeoi = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 19) == 0) r_smm = ~r_smm;
            r_i1  = ($urandom_range(0, 3) == 0);
            r_i2  = ($urandom_range(0, 3) == 0);
            r_ov  = ($urandom_range(0, 5) == 0);
            r_cmd = 3'($urandom);
            r_lvl = 3'($urandom);
            drive(r_pend, r_aeoi, r_smm, r_i1, r_i2, r_ov, r_cmd, r_lvl);
            model_step(r_pend, r_aeoi, r_smm, r_i1, r_i2, r_ov, r_cmd, int'(r_lvl));
            @(posedge clk);
            #1;
            check_all($sformatf("rand%0d", c), m_isr, m_req, m_vv, 3'(m_vl), 3'(m_lp));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pic_in_service_ctrl.md
# pic_in_service_ctrl

Parametrised in-service controller for the interrupt controller. It holds the in-service register (ISR) and the rotating priority pointer. It runs the two-pulse acknowledge sequence and executes every OCW2 end-of-interrupt and rotation command. It sits between the masked request register / priority logic and the control logic and data-bus buffer, and replaces the combinational ISR of the previous generation with a clocked, N-level block.

## Interface
- `NUM_IRQ`, default 8: number of interrupt levels; legal range 2..32.
- `LVL_W`, default `$clog2(NUM_IRQ)`: level index width; derived, never overridden.
- `clk` input 1: single clock; everything is sampled on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `irq_pending` input NUM_IRQ: requests already masked by the IMR (IRR & ~IMR).
- `aeoi_en` input 1: 1 = automatic EOI (ICW4), 0 = normal EOI.
- `special_mask_en` input 1: special mask mode (OCW3).
- `inta_first` input 1: one-cycle pulse for the first INTA.
- `inta_second` input 1: one-cycle pulse for the second INTA.
- `ocw2_valid` input 1: one-cycle strobe; OCW2 was written.
- `ocw2_cmd` input 3: R, SL, EOI bits (D7..D5).
- `ocw2_level` input LVL_W: L field (D2..D0, zero-extended).
- `isr` output NUM_IRQ: in-service register.
- `int_req` output 1: registered interrupt request to the CPU.
- `vector_valid` output 1: one-cycle strobe in the cycle after `inta_second`.
- `vector_level` output LVL_W: level the vector is built from; held until the next ack.
- `lowest_prio` output LVL_W: current lowest-priority level.

## Operation
- Priority order is rotating: the highest priority is `lowest_prio+1` (mod NUM_IRQ), descending from there.
- Eligible request:
  - Normal mode: a pending level with strictly higher priority than the highest-priority set ISR bit.
  - Special mask mode: any pending level whose ISR bit is clear.
- FSM states:
  - IDLE: on `inta_first`, go to ACK.
    - If an eligible request exists, latch its level (L) and set `isr[L]`.
    - Otherwise latch L = NUM_IRQ-1 (spurious) and leave `isr` unchanged.
  - ACK: on `inta_second`, return to IDLE, pulse `vector_valid` and drive `vector_level` = L.
    - If `aeoi_en`, clear `isr[L]`, except in the spurious case.
    - If `aeoi_en` and rotate-in-AEOI is set, also set `lowest_prio` = L.
  - `inta_first` in ACK and `inta_second` in IDLE are ignored.
- OCW2 (`ocw2_cmd`), applied in any state:
  - 001 non-specific EOI: clear the highest-priority set ISR bit.
  - 011 specific EOI: clear `isr[ocw2_level]`.
  - 101 rotate on non-specific EOI: clear the highest-priority set ISR bit (level H), then set `lowest_prio` = H.
  - 111 rotate on specific EOI: clear `isr[ocw2_level]`, `lowest_prio` = `ocw2_level`.
  - 110 set priority: `lowest_prio` = `ocw2_level`.
  - 100 set rotate-in-AEOI; 000 clear rotate-in-AEOI.
  - 010: no operation.
  - Non-specific EOI with an empty ISR changes nothing; its rotation variant also leaves `lowest_prio` unchanged.
- `int_req` is registered from (state == IDLE and an eligible request exists).

## Timing
- Reset values:
  - `isr` = 0, `int_req` = 0, `vector_valid` = 0, `vector_level` = 0.
  - `lowest_prio` = NUM_IRQ-1, rotate-in-AEOI = 0, FSM = IDLE.
- Reset asserted mid-sequence aborts the sequence; no vector is issued.
- An `isr` bit set by `inta_first` in cycle t is visible at t+1.
- `vector_valid` is high for exactly cycle t+1 after `inta_second` at t. The AEOI clear is visible at t+1.
- `int_req` reflects the inputs and state of cycle t at t+1. It is low throughout ACK.
- OCW2 takes effect at t+1; eligibility is recomputed from the new `isr` and `lowest_prio`.
- Simultaneous events:
  - `isr_next = (isr & ~clr) | set`; set wins on the same bit.
  - Non-specific EOI selects its target from `isr` before this cycle's set.
  - An OCW2 write of `lowest_prio` wins over an AEOI rotation in the same cycle.
- Level arithmetic is modulo NUM_IRQ; for non-power-of-2 NUM_IRQ, wrap explicitly from NUM_IRQ-1 to 0.
- `ocw2_level` ≥ NUM_IRQ: the command is ignored entirely.

## Structure
- `pic_pkg` holds:
  - OCW2 command localparams (`OCW2_NSEOI`, `OCW2_SEOI`, `OCW2_ROT_NSEOI`, `OCW2_ROT_SEOI`, `OCW2_SET_PRIO`, `OCW2_ROT_AEOI_SET`, `OCW2_ROT_AEOI_CLR`).
  - FSM state encoding (IDLE, ACK).
- Sub-module `pic_priority_resolver #(NUM_IRQ)`: rotating find-first (vector + `lowest_prio` -> found + level).
  - Instantiated twice: once on pending requests, once on `isr`.

## Test plan
All scenarios use NUM_IRQ = 8.
- Reset, then `irq_pending` = 0x24 -> `int_req` = 1 next cycle; ack pair -> `isr` = 0x04, `vector_level` = 2, `vector_valid` one cycle.
- `isr` = 0x04; pending 0x01, then pending 0x08 -> level 0 nests (`isr` = 0x05); level 3 gives no `int_req`. OCW2 001 twice -> `isr` 0x04, then 0x00.
- `aeoi_en` = 1, rotate-in-AEOI set, pending 0x10, ack -> `isr` = 0 after the second ack, `lowest_prio` = 4; next priority order starts at 5.
- `inta_first` with no pending -> `vector_level` = 7, `isr` unchanged.
- OCW2 110 with L = 2 -> `lowest_prio` = 2; pending 0x09 -> level 3 is serviced before level 0.
- Special mask on, `isr` = 0x01, pending 0x80 -> `int_req` = 1. Reset asserted in ACK -> all outputs return to reset values, no `vector_valid`.
